// File: rtl/apb_debug_bridge.sv
// UART (8N1) command frames in, one APB transfer per frame, ACK/NAK/read data out on txd.
// SETUP follows the last stop-bit sample by one cycle; no backpressure, bytes arriving mid-transfer are dropped.
module apb_debug_bridge #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT      = 1024
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        rxd,
  output logic        txd,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  output logic        busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_END   = TW'(TIMEOUT - 1);
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_e;
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_SETUP, P_ACCESS, P_RESP} p_st_e;

  logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  rx_st_e        rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  p_st_e         p_st_q, p_st_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic          is_wr_q, is_wr_d;
  logic [31:0]   addr_sh_q, addr_sh_d, data_sh_q, data_sh_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [31:0]   paddr_q, paddr_d, pwdata_q, pwdata_d;
  logic          tx_act_q, tx_act_d, txd_q, txd_d;
  logic [8:0]    tx_sh_q, tx_sh_d;
  logic [3:0]    tx_bits_q, tx_bits_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [23:0]   resp_q, resp_d;
  logic [1:0]    resp_n_q, resp_n_d;
  logic          busy_q, busy_d;

  logic       rx_done, rx_ok, rx_ferr, tx_last_done, tx_load;
  logic [7:0] tx_byte;

  always_comb begin
    rx_s1_d    = rxd;
    rx_s2_d    = rx_s1_q;
    rx_prev_d  = rx_s2_q;
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    p_st_d     = p_st_q;
    byte_cnt_d = byte_cnt_q;
    is_wr_d    = is_wr_q;
    addr_sh_d  = addr_sh_q;
    data_sh_d  = data_sh_q;
    to_cnt_d   = to_cnt_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    tx_act_d   = tx_act_q;
    txd_d      = txd_q;
    tx_sh_d    = tx_sh_q;
    tx_bits_d  = tx_bits_q;
    tx_cnt_d   = tx_cnt_q;
    resp_d     = resp_q;
    resp_n_d   = resp_n_q;
    busy_d     = busy_q;
    rx_done    = 1'b0;
    tx_load    = 1'b0;
    tx_byte    = NAK;

    // Receiver: start is a falling edge, confirmed again at mid-bit.
    case (rx_st_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_st_d  = RX_START;
          rx_cnt_d = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_done = 1'b1;
          rx_st_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
    rx_ok   = rx_done && rx_s2_q;
    rx_ferr = rx_done && !rx_s2_q;

    tx_last_done = tx_act_q && (tx_cnt_q == BIT_END) && (tx_bits_q == 4'd0);
    if (tx_act_q) begin
      if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0;
        if (tx_bits_q != 4'd0) begin
          txd_d     = tx_sh_q[0];
          tx_sh_d   = {1'b1, tx_sh_q[8:1]};
          tx_bits_d = tx_bits_q - 4'd1;
        end else begin
          tx_act_d = 1'b0;
          txd_d    = 1'b1;
        end
      end else begin
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
    end

    case (p_st_q)
      P_IDLE: begin
        if (rx_ok) begin
          busy_d     = 1'b1;
          byte_cnt_d = '0;
          if (rx_sh_q == CMD_W || rx_sh_q == CMD_R) begin
            is_wr_d = (rx_sh_q == CMD_W);
            p_st_d  = P_ADDR;
          end else begin
            tx_load  = 1'b1;
            tx_byte  = NAK;
            resp_n_d = '0;
            p_st_d   = P_RESP;
          end
        end
      end
      P_ADDR: begin
        if (rx_ferr) begin
          p_st_d = P_IDLE;
          busy_d = 1'b0;
        end else if (rx_ok) begin
          addr_sh_d  = {addr_sh_q[23:0], rx_sh_q};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (is_wr_q) begin
              p_st_d = P_DATA;
            end else begin
              p_st_d   = P_SETUP;
              psel_d   = 1'b1;
              pwrite_d = 1'b0;
              paddr_d  = {addr_sh_q[23:0], rx_sh_q};
            end
          end
        end
      end
      P_DATA: begin
        if (rx_ferr) begin
          p_st_d = P_IDLE;
          busy_d = 1'b0;
        end else if (rx_ok) begin
          data_sh_d  = {data_sh_q[23:0], rx_sh_q};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            p_st_d   = P_SETUP;
            psel_d   = 1'b1;
            pwrite_d = 1'b1;
            paddr_d  = addr_sh_q;
            pwdata_d = {data_sh_q[23:0], rx_sh_q};
          end
        end
      end
      P_SETUP: begin
        penable_d = 1'b1;
        to_cnt_d  = '0;
        p_st_d    = P_ACCESS;
      end
      P_ACCESS: begin
        // A ready slave on the final counted cycle still wins over the abort.
        if (PREADY) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          p_st_d    = P_RESP;
          tx_load   = 1'b1;
          if (pwrite_q) begin
            tx_byte  = ACK;
            resp_n_d = '0;
          end else begin
            tx_byte  = PRDATA[31:24];
            resp_d   = PRDATA[23:0];
            resp_n_d = 2'd3;
          end
        end else if (to_cnt_q == TO_END) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          p_st_d    = P_RESP;
          tx_load   = 1'b1;
          tx_byte   = NAK;
          resp_n_d  = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      P_RESP: begin
        if (tx_last_done) begin
          if (resp_n_q != 2'd0) begin
            tx_load  = 1'b1;
            tx_byte  = resp_q[23:16];
            resp_d   = {resp_q[15:0], 8'h00};
            resp_n_d = resp_n_q - 2'd1;
          end else begin
            p_st_d = P_IDLE;
            busy_d = 1'b0;
          end
        end
      end
      default: p_st_d = P_IDLE;
    endcase

    if (tx_load) begin
      tx_act_d  = 1'b1;
      txd_d     = 1'b0;
      tx_sh_d   = {1'b1, tx_byte};
      tx_bits_d = 4'd9;
      tx_cnt_d  = '0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      p_st_q     <= P_IDLE;
      byte_cnt_q <= '0;
      is_wr_q    <= 1'b0;
      addr_sh_q  <= '0;
      data_sh_q  <= '0;
      to_cnt_q   <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      tx_act_q   <= 1'b0;
      txd_q      <= 1'b1;
      tx_sh_q    <= '1;
      tx_bits_q  <= '0;
      tx_cnt_q   <= '0;
      resp_q     <= '0;
      resp_n_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_prev_q  <= rx_prev_d;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      p_st_q     <= p_st_d;
      byte_cnt_q <= byte_cnt_d;
      is_wr_q    <= is_wr_d;
      addr_sh_q  <= addr_sh_d;
      data_sh_q  <= data_sh_d;
      to_cnt_q   <= to_cnt_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      tx_act_q   <= tx_act_d;
      txd_q      <= txd_d;
      tx_sh_q    <= tx_sh_d;
      tx_bits_q  <= tx_bits_d;
      tx_cnt_q   <= tx_cnt_d;
      resp_q     <= resp_d;
      resp_n_q   <= resp_n_d;
      busy_q     <= busy_d;
    end
  end

  assign txd     = txd_q;
  assign PADDR   = paddr_q;
  assign PWRITE  = pwrite_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWDATA  = pwdata_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_apb_debug_bridge.sv
// Randomized frames against a frame-level model; APB and UART monitors pop expectations from queues.
module tb_apb_debug_bridge;
  localparam int CPB = 16;
  localparam int TO  = 8;

  logic clk = 1'b0;
  logic PRESET, rxd, txd, PWRITE, PSEL, PENABLE, PREADY, busy;
  logic [31:0] PADDR, PWDATA, PRDATA;

  apb_debug_bridge #(.CLKS_PER_BIT(CPB), .TIMEOUT(TO)) dut (
    .PCLK(clk), .PRESET(PRESET), .rxd(rxd), .txd(txd), .PADDR(PADDR),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          acc;
    logic        to;
  } apb_t;

  logic [7:0] exp_tx[$];
  apb_t       exp_apb[$];
  int checks = 0, passes = 0;
  int cyc = 0, comp_cyc = 0, tx_start_cyc = 0;
  bit tx_started = 0;
  int ws_cur = 0;
  logic [31:0] rd_val = 0;

  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Slave model: PREADY after ws_cur wait states, PRDATA valid only with PREADY.
  initial begin
    int dcnt;
    dcnt = 0; PREADY = 1'b0; PRDATA = '0;
    forever begin
      @(posedge clk); #1;
      if (PSEL && PENABLE) begin
        PREADY = (dcnt >= ws_cur);
        PRDATA = PREADY ? rd_val : $urandom;
        dcnt++;
      end else begin
        dcnt = 0;
        PREADY = 1'($urandom_range(0, 1));
        PRDATA = $urandom;
      end
    end
  end

  task automatic finish_xfer(input int acc, input logic timed_out);
    apb_t e;
    if (exp_apb.size() == 0) begin
      checks++;
      $display("FAIL apb_unexpected: got transfer addr %0h expected none", PADDR);
    end else begin
      e = exp_apb.pop_front();
      check("apb_addr", PADDR, e.addr);
      check("apb_write", PWRITE, e.wr);
      if (e.wr) check("apb_wdata", PWDATA, e.wdata);
      check("apb_access_cycles", acc, e.acc);
      check("apb_timeout", timed_out, e.to);
    end
  endtask

  initial begin
    int acc;
    bit in_acc;
    acc = 0; in_acc = 0;
    forever begin
      @(negedge clk);
      if (!PRESET) begin
        acc = 0; in_acc = 0;
      end else if (PSEL && PENABLE) begin
        acc++; in_acc = 1;
        if (PREADY) begin
          comp_cyc = cyc;
          finish_xfer(acc, 1'b0);
          acc = 0; in_acc = 0;
        end
      end else if (in_acc) begin
        comp_cyc = cyc - 1;
        finish_xfer(acc, 1'b1);
        acc = 0; in_acc = 0;
      end
    end
  end

  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (PRESET && txd == 1'b0) begin
        if (!tx_started) begin tx_started = 1; tx_start_cyc = cyc; end
        repeat (CPB/2) @(negedge clk);
        b = '0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        check("tx_stop_bit", txd, 1'b1);
        if (exp_tx.size() == 0) begin
          checks++;
          $display("FAIL tx_unexpected: got byte %0h expected none", b);
        end else begin
          check("tx_byte", b, exp_tx.pop_front());
        end
      end
    end
  end

  task automatic uart_send(input logic [7:0] b, input bit bad_stop);
    rxd = 1'b0; repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rxd = b[i]; repeat (CPB) @(negedge clk); end
    rxd = bad_stop ? 1'b0 : 1'b1; repeat (CPB) @(negedge clk);
    rxd = 1'b1; repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) uart_send(w[8*i +: 8], 1'b0);
  endtask

  task automatic wait_done(input bit had_apb);
    int n;
    n = 0;
    while ((busy || exp_tx.size() != 0 || exp_apb.size() != 0) && n < 3000) begin
      @(negedge clk); n++;
    end
    check("done_within_budget", n < 3000, 1'b1);
    check("tx_queue_drained", exp_tx.size(), 0);
    check("apb_queue_drained", exp_apb.size(), 0);
    if (had_apb) check("resp_latency", 64'(tx_start_cyc - comp_cyc), 64'd1);
    repeat (CPB) @(negedge clk);
  endtask

  function automatic apb_t mk(input logic [31:0] a, input logic w, input logic [31:0] d, input int ws);
    apb_t e;
    e.addr = a; e.wr = w; e.wdata = d;
    e.to  = (ws >= TO);
    e.acc = (ws >= TO) ? TO : ws + 1;
    return e;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int ws);
    ws_cur = ws; tx_started = 0;
    exp_apb.push_back(mk(a, 1'b1, d, ws));
    exp_tx.push_back((ws >= TO) ? 8'h15 : 8'h06);
    uart_send(8'h57, 1'b0); send_word(a); send_word(d);
    wait_done(1'b1);
    check("paddr_hold", PADDR, a);
    check("pwrite_hold", PWRITE, 1'b1);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input int ws);
    ws_cur = ws; rd_val = d; tx_started = 0;
    exp_apb.push_back(mk(a, 1'b0, 32'h0, ws));
    if (ws >= TO) exp_tx.push_back(8'h15);
    else for (int i = 3; i >= 0; i--) exp_tx.push_back(d[8*i +: 8]);
    uart_send(8'h52, 1'b0); send_word(a);
    wait_done(1'b1);
    check("paddr_hold", PADDR, a);
  endtask

  task automatic check_reset(input string p);
    check({p, "_txd"}, txd, 1'b1);
    check({p, "_psel"}, PSEL, 1'b0);
    check({p, "_penable"}, PENABLE, 1'b0);
    check({p, "_pwrite"}, PWRITE, 1'b0);
    check({p, "_paddr"}, PADDR, 32'h0);
    check({p, "_pwdata"}, PWDATA, 32'h0);
    check({p, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    rxd = 1'b1; PRESET = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    PRESET = 1'b1;
    repeat (5) @(negedge clk);

    do_write(32'h4000_2000, 32'hDEAD_BEEF, 0);
    do_read(32'h1000_4000, 32'h1234_5678, 3);
    do_read(32'h2000_0010, 32'hCAFE_F00D, 100);
    do_read(32'h2000_0014, 32'hA5A5_0FF0, TO - 1);
    do_write(32'h3000_0000, 32'h0BAD_CAFE, TO);

    exp_tx.push_back(8'h15); tx_started = 0;
    uart_send(8'h41, 1'b0);
    wait_done(1'b0);
    uart_send(8'h57, 1'b1);
    repeat (20*CPB) @(negedge clk);
    check("ferr_busy", busy, 1'b0);
    do_write(32'h4000_0100, 32'h0000_0001, 1);

    rxd = 1'b0; repeat (3) @(negedge clk); rxd = 1'b1;
    repeat (20*CPB) @(negedge clk);
    check("glitch_busy", busy, 1'b0);
    check("glitch_txd", txd, 1'b1);

    uart_send(8'h57, 1'b0); send_word(32'h5555_0000);
    rxd = 1'b0; repeat (CPB) @(negedge clk);
    rxd = 1'b1; repeat (CPB) @(negedge clk);
    rxd = 1'b0; repeat (CPB) @(negedge clk);
    check("busy_mid_frame", busy, 1'b1);
    PRESET = 1'b0; rxd = 1'b1; #1;
    check_reset("reset_mid");
    repeat (5) @(negedge clk);
    PRESET = 1'b1;
    repeat (20*CPB) @(negedge clk);
    check("after_reset_busy", busy, 1'b0);
    check("after_reset_psel", PSEL, 1'b0);
    do_write(32'h6000_0040, 32'h1357_9BDF, 2);

    for (int k = 0; k < 6; k++) begin
      logic [31:0] a, d;
      int ws;
      a = $urandom; d = $urandom;
      ws = ($urandom_range(0, 4) == 0) ? TO + int'($urandom_range(0, 3)) : int'($urandom_range(0, TO - 1));
      if ($urandom_range(0, 1) == 1) do_write(a, d, ws);
      else do_read(a, d, ws);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/apb_debug_bridge.md
# apb_debug_bridge

UART-driven APB initiator that gives a host PC direct read/write access to the MCU's peripheral bus without CPU involvement. It receives 8N1 command frames on `rxd`, issues one APB transfer per frame, and answers on `txd`. It sits beside the CPU's APB master and feeds the same slave decoder through an external arbiter; PSEL is a single request line.

## Interface
Parameters:
- CLKS_PER_BIT, 868: PCLK cycles per UART bit (100 MHz / 115200); must be ≥ 8.
- TIMEOUT, 1024: maximum ACCESS-phase cycles to wait for PREADY before aborting.

Ports:
- PCLK  input  1  bus clock; all logic is on the rising edge.
- PRESET  input  1  asynchronous, active-low reset.
- rxd  input  1  UART receive line, idle high, asynchronous to PCLK.
- txd  output  1  UART transmit line, idle high.
- PADDR  output  32  APB address.
- PWRITE  output  1  1 = write, 0 = read.
- PSEL  output  1  APB select (transfer request).
- PENABLE  output  1  APB access phase.
- PWDATA  output  32  APB write data.
- PRDATA  input  32  APB read data, valid when PREADY = 1.
- PREADY  input  1  slave ready.
- busy  output  1  high from the first command byte until the response's last stop bit.

## Operation
- rxd passes through a 2-flop synchronizer before use.
- RX: a falling edge in idle starts a byte. Re-sample at CLKS_PER_BIT/2; if rxd is high, the start bit was false and RX returns to idle. Otherwise sample 8 data bits, LSB first, at CLKS_PER_BIT intervals, then the stop bit. A stop bit of 0 is a framing error: the byte is dropped and the parser resets to IDLE with no response.
- TX: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts CLKS_PER_BIT cycles. Bytes are sent back-to-back.
- Frames: all multi-byte fields are MSB first.
  - Write frame: 0x57 ('W'), ADDR[4], DATA[4]. Performs an APB write, then sends 0x06 (ACK).
  - Read frame: 0x52 ('R'), ADDR[4]. Performs an APB read, then sends PRDATA as 4 bytes.
  - Any other command byte: send 0x15 (NAK) and return to IDLE.
- Parser FSM: IDLE → CMD → ADDR (4 bytes) → [DATA (4 bytes) for writes] → SETUP → ACCESS → RESP → IDLE.
- Bytes received during SETUP, ACCESS or RESP are discarded.
- Timeout: if ACCESS lasts TIMEOUT cycles without PREADY, drop PSEL and PENABLE and send NAK. For reads, the NAK replaces the 4 data bytes.
- PADDR, PWDATA and PWRITE hold their values from SETUP until the next transfer.

## Timing
- Reset values: txd=1, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, busy=0. All counters and FSMs go to idle.
- Reset mid-operation: asserting PRESET aborts any byte, transfer or response immediately. No partial frame survives reset.
- SETUP begins on the cycle after the final frame byte's stop-bit sample: PSEL=1, PENABLE=0 for exactly one cycle.
- ACCESS: PSEL=1, PENABLE=1. PREADY is sampled each cycle. On the first cycle with PREADY=1:
  - PRDATA is captured.
  - PSEL and PENABLE are both 0 on the next cycle.
- Minimum transfer is 2 cycles (PREADY=1 on the first ACCESS cycle).
- The timeout counter starts at 0 on the first ACCESS cycle. It aborts when the count reaches TIMEOUT-1 with PREADY still 0.
- PREADY=1 on the timeout cycle: the transfer succeeds, not the timeout.
- The response start bit begins on the cycle after the APB transfer completes.
- busy falls on the cycle after the last stop bit finishes.

## Test plan
- Write: with CLKS_PER_BIT=16, send 57 40 00 20 00 DE AD BE EF and PREADY tied 1. Expect one SETUP+ACCESS with PADDR=0x4000_2000, PWDATA=0xDEADBEEF, PWRITE=1, then txd byte 0x06.
- Read with wait states: send 52 10 00 40 00, with PREADY held low for 3 ACCESS cycles and PRDATA=0x1234_5678. Expect PENABLE high for 4 cycles, then txd bytes 12 34 56 78.
- Timeout: TIMEOUT=8, read frame, PREADY stuck 0. Expect PSEL to drop after 8 ACCESS cycles, txd sends 0x15, and the next valid frame works normally.
- Bad command plus framing error: byte 0x41 → NAK 0x15. A 0x57 byte whose stop bit is forced 0 → no response and no APB activity. Then a full valid write frame → ACK.
- Glitch and reset: a 3-cycle low pulse on idle rxd → ignored. Assert PRESET during byte 6 of a write frame → all outputs at reset values, no APB transfer. A new frame after reset completes normally.
